branch_predictor_bimodal: RTL

Bimodal branch predictor that consumes the single-cycle bp_update pulse produced by the execution condition register file when a branch resolves. Holds a table of 2-bit saturating counters indexed by PC. Serves combinational taken/not-taken predictions to the issue controller, which forwards the prediction back to the ECR file as branch metadata. After reset, a sweep FSM initialises the table one entry per cycle, RAM-style.

---
 rtl/branch_predictor_bimodal_pkg.sv | 21 ++
 rtl/branch_predictor_bimodal_sat_counter2.sv | 20 ++
 rtl/branch_predictor_bimodal.sv | 109 ++++++++++
 3 files changed

// File: rtl/branch_predictor_bimodal_pkg.sv
// Shared types for the bimodal branch predictor: the ECR update payload,
// the 2-bit counter encodings and the init/ready state enum.
package branch_predictor_bimodal_pkg;

  typedef struct packed {
    logic        en;
    logic [31:0] pc;
    logic        actual_taken;
  } bp_update_t;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  typedef enum logic {
    S_INIT,
    S_READY
  } bp_state_e;

endpackage

// File: rtl/branch_predictor_bimodal_sat_counter2.sv
// Combinational 2-bit saturating counter step: increment on taken,
// decrement on not-taken, clamped at strongly taken / strongly not-taken.
module bp_sat_counter2
  import branch_predictor_bimodal_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken && (cur != BP_ST)) begin
      nxt = cur + 2'd1;
    end else if (!taken && (cur != BP_SNT)) begin
      nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_bimodal.sv
// Bimodal predictor: PC-indexed table of 2-bit counters, initialised by a
// post-reset sweep, trained by a two-stage update pipeline with lookup bypass.
module branch_predictor_bimodal
  import branch_predictor_bimodal_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES  = 256,
  parameter logic [1:0]  INIT_COUNTER = BP_WNT,
  parameter int unsigned STAT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_en,
  input  logic [31:0]       lookup_pc,
  output logic              pred_taken,
  output logic              pred_valid,
  input  bp_update_t        bp_update,
  output logic              init_busy,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned     IDX_W    = $clog2(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  bp_state_e        state_q;
  bp_state_e        state_d;
  logic [IDX_W-1:0] init_idx_q;
  logic [1:0]       table_q [NUM_ENTRIES];

  logic             upd_en_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic             upd_taken_q;

  logic [IDX_W-1:0] lookup_idx;
  logic [1:0]       cur;
  logic [1:0]       nxt;
  logic [1:0]       eff;

  // Upper/lower PC bits carry no index information (no tags, word-aligned).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                            bp_update.pc[31:IDX_W+2], bp_update.pc[1:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (init_idx_q == LAST_IDX) state_d = S_READY;
      S_READY: state_d = S_READY;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) init_idx_q <= init_idx_q + IDX_W'(1);
    end
  end

  // Table storage has no reset; the sweep defines every entry before use.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      table_q[init_idx_q] <= INIT_COUNTER;
    end else if (upd_en_q) begin
      table_q[upd_idx_q] <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_en_q    <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      upd_en_q    <= bp_update.en && (state_q == S_READY);
      upd_idx_q   <= bp_update.pc[IDX_W+1:2];
      upd_taken_q <= bp_update.actual_taken;
    end
  end

  assign cur = table_q[upd_idx_q];

  bp_sat_counter2 u_sat (
    .cur   (cur),
    .taken (upd_taken_q),
    .nxt   (nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (upd_en_q) begin
      stat_updates <= stat_updates + STAT_W'(1);
      if (cur[1] != upd_taken_q) stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end

  // Bypass lets a lookup observe the update being written this cycle.
  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign eff        = (upd_en_q && (upd_idx_q == lookup_idx)) ? nxt : table_q[lookup_idx];
  assign pred_taken = (state_q == S_READY) && eff[1];
  assign pred_valid = lookup_en && (state_q == S_READY);
  assign init_busy  = (state_q == S_INIT);

endmodule
